// File: rtl/signed_mult4_rr_scheduler_if.sv
// Operand/result bundle for the shared 4x4 signed multiplier scheduler.
// Requester i owns bit i of req_valid/req_ready and nibble [4i+3:4i] of req_a/req_b.
interface signed_mult4_rr_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_product;
  logic [1:0]           out_id;
  logic [CNT_W-1:0]     op_count;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_product, out_id, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_product, out_id, op_count
  );
endinterface

// File: rtl/signed_mult4_rr_scheduler.sv
// Round-robin scheduler time-multiplexing one 4x4 signed array multiplier over
// four requesters, with a single registered, ID-tagged result slot.
module signed_mult4_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input logic                        clk,
  input logic                        rst,
  signed_mult4_rr_scheduler_if.slave bus
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       product_q, product_d;
  logic [1:0]       id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_any;
  logic [1:0]       grant_id;
  logic [1:0]       scan_idx;
  logic             can_accept;
  logic [3:0]       ready;
  logic             xfer;
  logic [3:0]       op_a, op_b;
  logic [7:0]       a_ext, acc;

  // Search from the pointer; 2-bit index wraps naturally modulo four requesters.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = ptr_q;
    scan_idx  = ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  // A draining result frees the slot in the same cycle.
  assign can_accept    = (state_q == StEmpty) || bus.out_ready;
  assign ready         = (!rst && can_accept && grant_any) ? (4'b0001 << grant_id) : 4'b0000;
  assign xfer          = |ready;
  assign bus.req_ready = ready;

  assign op_a = bus.req_a[{grant_id, 2'b00} +: 4];
  assign op_b = bus.req_b[{grant_id, 2'b00} +: 4];

  // Shift-add array: rows 0..2 add, the sign row of B subtracts (two's complement weight -8).
  always_comb begin
    a_ext = {{4{op_a[3]}}, op_a};
    acc   = 8'h00;
    for (int unsigned i = 0; i < 3; i++) begin
      if (op_b[i]) begin
        acc = acc + (a_ext << i);
      end
    end
    if (op_b[3]) begin
      acc = acc - (a_ext << 3);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    product_d = product_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    if (xfer) begin
      state_d   = StFull;
      product_d = acc;
      id_d      = grant_id;
      ptr_d     = grant_id + 2'd1;
      cnt_d     = cnt_q + CNT_W'(1);
    end else begin
      unique case (state_q)
        StFull:  if (bus.out_ready) state_d = StEmpty;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      ptr_q     <= 2'd0;
      product_q <= 8'h00;
      id_q      <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      product_q <= product_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_valid   = (state_q == StFull);
  assign bus.out_product = product_q;
  assign bus.out_id      = id_q;
  assign bus.op_count    = cnt_q;

endmodule

// File: tb/tb_signed_mult4_rr_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of grant order, product arithmetic and the result slot.
module tb_signed_mult4_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 4;  // narrow so the random run exercises wraparound

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signed_mult4_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  signed_mult4_rr_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic             m_valid;
  logic [7:0]       m_prod;
  logic [1:0]       m_id;
  logic [CNT_W-1:0] m_cnt;
  int               m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_ready(input logic r, input logic [3:0] v, input logic ordy);
    if (r) return 4'b0000;
    if (m_valid && !ordy) return 4'b0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (v[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  function automatic logic [7:0] ref_mult(input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return 8'(ia * ib);
  endfunction

  task automatic model_step(input logic r, input logic [3:0] gr, input logic [15:0] a,
                            input logic [15:0] b, input logic ordy);
    if (r) begin
      m_valid = 1'b0;
      m_prod  = 8'h00;
      m_id    = 2'd0;
      m_cnt   = '0;
      m_ptr   = 0;
    end else if (gr != 4'b0000) begin
      int g;
      g = 0;
      for (int i = 0; i < NUM_REQ; i++) if (gr[i]) g = i;
      m_prod  = ref_mult(a[4*g +: 4], b[4*g +: 4]);
      m_id    = 2'(g);
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NUM_REQ;
      m_cnt   = m_cnt + 1'b1;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive at negedge, check grant, advance model on posedge, check outputs.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [15:0] a,
                       input logic [15:0] b, input logic ordy, output logic [3:0] gr);
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.out_ready = ordy;
    #1;
    gr = model_ready(r, v, ordy);
    check_eq("req_ready", 32'(bus.req_ready), 32'(gr));
    @(posedge clk);
    model_step(r, gr, a, b, ordy);
    #1;
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check_eq("out_product", 32'(bus.out_product), 32'(m_prod));
    check_eq("out_id", 32'(bus.out_id), 32'(m_id));
    check_eq("op_count", 32'(bus.op_count), 32'(m_cnt));
  endtask

  logic [3:0]  gr;
  logic [3:0]  pend;
  logic [15:0] ra, rb;
  logic [15:0] ops_a [4];
  logic [15:0] ops_b [4];
  logic [7:0]  prods [4];

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.out_ready = 1'b1;
    m_valid = 1'b0; m_prod = '0; m_id = '0; m_cnt = '0; m_ptr = 0;

    // Reset held two cycles with every requester valid.
    repeat (2) begin
      cycle(1'b1, 4'hF, 16'h1111, 16'h1111, 1'b1, gr);
      check_eq("rst_ready", 32'(bus.req_ready), 32'h0);
      check_eq("rst_valid", 32'(bus.out_valid), 32'h0);
      check_eq("rst_count", 32'(bus.op_count), 32'h0);
    end
    cycle(1'b0, 4'hF, 16'h1111, 16'h1111, 1'b1, gr);
    check_eq("first_grant", 32'(bus.out_id), 32'h0);

    // Single request from requester 1: -6 * 3.
    cycle(1'b1, 4'h0, 16'h0, 16'h0, 1'b1, gr);
    cycle(1'b0, 4'b0010, 16'h00A0, 16'h0030, 1'b1, gr);
    check_eq("single_valid", 32'(bus.out_valid), 32'h1);
    check_eq("single_prod", 32'(bus.out_product), 32'hEE);
    check_eq("single_id", 32'(bus.out_id), 32'h1);
    check_eq("single_count", 32'(bus.op_count), 32'h1);

    // Round robin under full load.
    cycle(1'b1, 4'h0, 16'h0, 16'h0, 1'b1, gr);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'hF, 16'h4321, 16'h1234, 1'b1, gr);
      check_eq("rr_id", 32'(bus.out_id), 32'(k % 4));
    end

    // Backpressure: requester 0 computes 3*5, then the slot is held three cycles.
    cycle(1'b1, 4'h0, 16'h0, 16'h0, 1'b1, gr);
    cycle(1'b0, 4'hF, 16'h7773, 16'h2225, 1'b1, gr);
    repeat (3) begin
      cycle(1'b0, 4'hE, 16'h7773, 16'h2225, 1'b0, gr);
      check_eq("bp_ready", 32'(bus.req_ready), 32'h0);
      check_eq("bp_prod", 32'(bus.out_product), 32'h0F);
      check_eq("bp_id", 32'(bus.out_id), 32'h0);
    end
    cycle(1'b0, 4'hE, 16'h7773, 16'h2225, 1'b1, gr);
    check_eq("bp_nobubble_valid", 32'(bus.out_valid), 32'h1);
    check_eq("bp_nobubble_id", 32'(bus.out_id), 32'h1);
    check_eq("bp_nobubble_prod", 32'(bus.out_product), 32'h0E);

    // Corner products on requester 0.
    cycle(1'b1, 4'h0, 16'h0, 16'h0, 1'b1, gr);
    ops_a = '{16'h000D, 16'h0008, 16'h0008, 16'h0000};
    ops_b = '{16'h000A, 16'h0008, 16'h0007, 16'h000B};
    prods = '{8'h12, 8'h40, 8'hC8, 8'h00};
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 4'b0001, ops_a[k], ops_b[k], 1'b1, gr);
      check_eq("corner_prod", 32'(bus.out_product), 32'(prods[k]));
    end

    // Reset while a result is pending and five transfers have been counted.
    cycle(1'b1, 4'h0, 16'h0, 16'h0, 1'b1, gr);
    repeat (5) cycle(1'b0, 4'b0100, 16'h0300, 16'h0200, 1'b1, gr);
    check_eq("mid_count", 32'(bus.op_count), 32'h5);
    cycle(1'b1, 4'hF, 16'h0, 16'h0, 1'b0, gr);
    check_eq("mid_valid", 32'(bus.out_valid), 32'h0);
    check_eq("mid_count_clr", 32'(bus.op_count), 32'h0);
    cycle(1'b0, 4'hF, 16'h0, 16'h0, 1'b1, gr);
    check_eq("mid_ptr_clr", 32'(bus.out_id), 32'h0);

    // Randomized traffic: requesters hold operands until granted.
    pend = 4'b0000;
    ra   = '0;
    rb   = '0;
    for (int n = 0; n < 600; n++) begin
      logic r;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && ($urandom_range(1) == 1)) begin
          pend[i]      = 1'b1;
          ra[4*i +: 4] = 4'($urandom);
          rb[4*i +: 4] = 4'($urandom);
        end
      end
      r = ($urandom_range(63) == 0);
      cycle(r, pend, ra, rb, ($urandom_range(3) != 0), gr);
      pend = pend & ~gr;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/signed_mult4_rr_scheduler.md
Name: signed_mult4_rr_scheduler

Overview:
- Shares one combinational array_signed_multiplier_4 (4x4 signed, 8-bit product) among NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready handshake on each request port, and a single-entry registered result buffer.
- Each result is tagged with the requester ID and has 1-cycle latency.
- Sits between operand producers and the consumer of products, so one multiplier array can be time-multiplexed.

Parameters:
- NUM_REQ, 4, number of requesters; only 4 supported (ID width fixed at 2).
- CNT_W, 16, width of accepted-transaction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  4*NUM_REQ  signed operand A; requester i at [4i+3:4i].
- req_b  input  4*NUM_REQ  signed operand B; same packing.
- out_valid  output  1  result buffer holds a valid product.
- out_ready  input  1  consumer accepts the result.
- out_product  output  8  signed product A*B.
- out_id  output  2  index of the requester that produced out_product.
- op_count  output  CNT_W  number of accepted requests, wraps modulo 2^CNT_W.

Behaviour:
- Reset applies on the rising edge of clk while rst=1:
  - out_valid=0, out_product=0, out_id=0, op_count=0, rr pointer ptr=0.
  - req_ready is forced to 0 while rst=1.
- State: single buffer with two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid | out_ready. A draining result frees the slot in the same cycle.
- Arbitration (combinational):
  - g = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NUM_REQ.
  - If can_accept and any req_valid: req_ready = one-hot(g). Otherwise req_ready = 0.
  - req_ready may depend combinationally on req_valid and out_ready.
- Handshake: a transfer on port i occurs when req_valid[i] & req_ready[i] are both 1 at a clock edge. Requesters hold valid and operands stable until accepted.
- On transfer (the multiplier instance is fed the muxed operands of g):
  - out_product <= product(A_g, B_g); out_id <= g; out_valid <= 1.
  - ptr <= (g+1) mod NUM_REQ; op_count <= op_count+1.
- No transfer, with out_valid & out_ready: out_valid <= 0. out_product and out_id keep their last values.
- No transfer, with out_valid & !out_ready: all outputs hold stable (backpressure). ptr does not move.
- Latency and throughput: the result appears the cycle after accept. Up to one result per cycle when out_ready=1 continuously.
- Fairness: with all requesters continuously valid and no backpressure, grants cycle 0,1,2,3,0,... Every requester is served within NUM_REQ accepted transfers of asserting valid.
- Arithmetic: two's complement, full 8-bit result with no overflow. Range is -56 (-8*7) to +64 (-8*-8).
- Counter: op_count wraps from 2^CNT_W-1 to 0 silently.
- Reset mid-operation: a pending result is discarded and the pointer and counter are cleared. No transfer is accepted in the reset cycle.
- Deassertion of req_valid before acceptance is a protocol violation; behaviour is undefined but must not hang the FSM.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with all req_valid=1. Required: req_ready=0, out_valid=0, op_count=0. After release, first grant goes to requester 0.
- Single request: req_valid=4'b0010, A1=4'b1010 (-6), B1=4'b0011 (3), out_ready=1. Required next cycle: out_valid=1, out_product=-18 (8'hEE), out_id=1, op_count=1.
- Round-robin under full load: req_valid=4'b1111 continuously, out_ready=1. Required: out_id sequence 0,1,2,3,0 on consecutive cycles; exactly one req_ready bit high per cycle.
- Backpressure: result FULL and out_ready=0 for 3 cycles. Required: req_ready=0; out_product and out_id stable. On out_ready=1, a new request is accepted in that same cycle and the new result appears the next cycle with no bubble.
- Corner products:
  - A=-3 (1101), B=-6 (1010) gives +18.
  - A=-8, B=-8 gives +64.
  - A=-8, B=7 gives -56.
  - A=0, B=-5 gives 0.
- Reset mid-operation: assert rst while out_valid=1 and op_count=5. Required next cycle: out_valid=0, op_count=0, ptr=0.
